onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Two-master arbiter that shares the single-port 32-bit on-chip RAM (13-bit word address, 5120 words, byte enables) between two Avalon-MM style requesters, e.g. CPU data master and DMA.
- Sits between the masters and the RAM slave port.
- Grants one access per cycle using round-robin, returns read data with fixed 1-cycle latency, and rejects out-of-range addresses.

Parameters:
- DEPTH, 5120, number of valid RAM words; addresses >= DEPTH are out of range.
- AW, 13, word address width.
- DW, 32, data width; byte-enable width is DW/8.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- reset_req  in  1  RAM reset request; stalls all traffic while high
- m0_address  in  AW  master 0 word address
- m0_byteenable  in  DW/8  master 0 byte enables
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DW  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DW  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m0_oor  out  1  out-of-range pulse, aligned with response
- m1_*  same set as m0_*, for master 1
- mem_address  out  AW  to RAM
- mem_byteenable  out  DW/8  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DW  to RAM
- mem_clken  out  1  RAM clock enable; equals ~reset_req
- mem_readdata  in  DW  RAM output, valid the cycle after the address is presented

Behaviour:
- Request definition: reqN = mN_read | mN_write. Read and write asserted together by the same master is illegal; treat it as a write.
- Grant (combinational, per cycle):
  - If reset_req=1 or reset: no grant; both waitrequests follow their requests.
  - Only one master requesting: that master wins.
  - Both requesting: the master not in last_grant wins.
  - last_grant register resets to 1, so m0 wins the first contention.
  - last_grant updates to the winner on each granted cycle.
- Waitrequest: mN_waitrequest = reqN & ~grantN. A master holds all signals stable while stalled; the access completes on the cycle it is granted.
- RAM drive:
  - mem_address, mem_byteenable, mem_writedata are muxed from the granted master; they hold the m0 values when there is no grant.
  - mem_chipselect = grant_any & in_range.
  - mem_write = granted write & in_range.
  - in_range = granted address < DEPTH.
- Out-of-range access:
  - Granted normally, with no RAM chipselect.
  - A write is dropped.
  - A read returns readdata = 0.
  - mN_oor pulses for 1 cycle in the response cycle. For a write, that is the cycle after the grant.
- Read response:
  - Registers rd_pend, rd_owner, rd_oor are captured on a granted read.
  - In cycle N+1, m{rd_owner}_readdatavalid = 1 and m{rd_owner}_readdata = rd_oor ? 0 : mem_readdata.
  - The non-owner's readdata is 0 and its readdatavalid is 0.
- Throughput:
  - Back-to-back granted reads are allowed every cycle; there are no bubbles.
  - Alternating masters under continuous contention gives 50/50 bandwidth.
- reset_req: mem_clken = ~reset_req. A read granted in the cycle before reset_req rises still completes, because its data was captured on the last enabled edge.
- Reset (asynchronous):
  - Clears rd_pend, rd_oor and the oor pulse registers; sets last_grant=1.
  - All valid and oor outputs are 0 while reset is held.
  - A read in flight at reset is discarded and no valid is issued.
- Simultaneous events: a new grant in the same cycle as a read response for the other master is legal; the two are independent.

Optional Feature:
- Macro: ONCHIP_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. m0 always wins contention; last_grant is not used and m1 may starve.
- Undefined (default): round-robin as specified above.

Test Plan:
- m0 write 0xA5A5_1234 to 0x0010 with be=4'hF, then m0 read 0x0010 -> m0_waitrequest=0 both cycles; m0_readdatavalid high exactly 1 cycle after the read grant with 0xA5A5_1234; m1_readdatavalid stays 0.
- m0 and m1 both read continuously from cycle 0 (addresses 0x0001 and 0x0002) -> grants go m0,m1,m0,m1...; each waitrequest is high every other cycle; valids alternate with the correct data; under ONCHIP_ARB_FIXED_PRIO_EN, m1_waitrequest stays high for the whole window.
- m1 write 0xFFFF_FFFF with be=4'b0010 over an existing 0x1122_3344 at 0x1000, then read -> 0x1122_FF44.
- m0 read at 0x1400 (=5120) and m1 write at 0x1FFF -> mem_chipselect=0 in both granted cycles; m0_readdatavalid=1 with readdata 0 and m0_oor=1; m1_oor pulses once; RAM contents unchanged.
- reset_req high for 3 cycles while m0 requests -> mem_clken=0 and m0_waitrequest=1 for those 3 cycles; access granted on the first cycle after reset_req falls.
- Assert reset in the cycle after a granted m1 read -> m1_readdatavalid never asserts; after release, m0 wins the first contention.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port on-chip RAM, with 1-cycle read return.
// Build option: define ONCHIP_ARB_FIXED_PRIO_EN for fixed priority (m0 always wins contention).
module onchip_mem_arbiter #(
  parameter int DEPTH = 5120,
  parameter int AW    = 13,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,

  input  logic [AW-1:0]     m0_address,
  input  logic [DW/8-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DW-1:0]     m0_writedata,
  output logic              m0_waitrequest,
  output logic [DW-1:0]     m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_oor,

  input  logic [AW-1:0]     m1_address,
  input  logic [DW/8-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DW-1:0]     m1_writedata,
  output logic              m1_waitrequest,
  output logic [DW-1:0]     m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_oor,

  output logic [AW-1:0]     mem_address,
  output logic [DW/8-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DW-1:0]     mem_writedata,
  output logic              mem_clken,
  input  logic [DW-1:0]     mem_readdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // Out-of-range reads and idle cycles return zero, never stale RAM output.
  function automatic logic [DW-1:0] rsp_data(input logic vld, input logic oor,
                                             input logic [DW-1:0] d);
    return (vld && !oor) ? d : '0;
  endfunction

  logic          req0, req1;
  logic          grant0, grant1, grant_any;
  logic          stall;
  logic [AW-1:0] g_addr;
  logic          g_write;
  logic          in_range;

  logic          rd_vld_p1;
  logic          rd_oor_p1;
  logic          rd_owner_p1;
  logic [1:0]    oor_p1;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign stall = reset | reset_req;

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!stall) begin
      if (req0)      grant0 = 1'b1;
      else if (req1) grant1 = 1'b1;
    end
  end
`else
  // last_grant: 0 = m0 won most recently, 1 = m1 won most recently.
  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!stall) begin
      if (req0 && !req1)      grant0 = 1'b1;
      else if (req1 && !req0) grant1 = 1'b1;
      else if (req0 && req1) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          last_grant <= 1'b1;
    else if (grant_any) last_grant <= grant1;
  end
`endif

  assign grant_any      = grant0 | grant1;
  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  // Idle cycles park the RAM bus on m0's signals.
  assign g_addr   = grant1 ? m1_address : m0_address;
  assign g_write  = grant1 ? m1_write   : m0_write;
  assign in_range = addr_in_range(g_addr);

  assign mem_address    = g_addr;
  assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = grant_any & in_range;
  assign mem_write      = grant_any & g_write & in_range;
  assign mem_clken      = ~reset_req;

  // ---- stage p0 -> p1: capture response control for the granted access ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_p1 <= 1'b0;
      rd_oor_p1 <= 1'b0;
      oor_p1    <= 2'b00;
    end else begin
      rd_vld_p1 <= grant_any & ~g_write;
      rd_oor_p1 <= grant_any & ~g_write & ~in_range;
      oor_p1[0] <= grant0 & ~in_range;
      oor_p1[1] <= grant1 & ~in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_any && !g_write) rd_owner_p1 <= grant1;
  end

  // ---- stage p1: route RAM output to the owning master ----
  assign m0_readdatavalid = rd_vld_p1 & ~rd_owner_p1;
  assign m1_readdatavalid = rd_vld_p1 &  rd_owner_p1;
  assign m0_readdata      = rsp_data(m0_readdatavalid, rd_oor_p1, mem_readdata);
  assign m1_readdata      = rsp_data(m1_readdatavalid, rd_oor_p1, mem_readdata);
  assign m0_oor           = oor_p1[0];
  assign m1_oor           = oor_p1[1];

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomized bench for onchip_mem_arbiter against a cycle-level model of the arbitration rules.
module tb_onchip_mem_arbiter;
  localparam int DEPTH = 5120;
  localparam int AW    = 13;
  localparam int DW    = 32;
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, reset_req;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [31:0]   m0_writedata, m1_writedata, mem_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [31:0]   m0_readdata, m1_readdata, mem_readdata;
  logic          m0_readdatavalid, m1_readdatavalid, m0_oor, m1_oor;
  logic          mem_chipselect, mem_write, mem_clken;
  logic          ram_clr;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid), .m0_oor(m0_oor),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid), .m1_oor(m1_oor),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Synchronous RAM with clock enable and registered read output.
  logic [31:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      mem_readdata <= '0;
    end else if (mem_clken && mem_chipselect) begin
      mem_readdata <= ram[mem_address];
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] model_mem [0:DEPTH-1];
  int          last_w;
  bit [1:0]    pend_vld, pend_oor;
  logic [31:0] pend_data [2];
  int          gnt;

  task automatic step();
    int g;
    bit r0, r1, gw, inr;
    logic [AW-1:0] ga;
    logic [31:0] wd;
    logic [3:0] be;
    @(negedge clk);
    r0 = m0_read || m0_write;
    r1 = m1_read || m1_write;
    g = -1;
    if (!(reset || reset_req)) begin
      if (r0 && r1) g = (FIXED || last_w == 1) ? 0 : 1;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
    end
    ga = (g == 1) ? m1_address    : m0_address;
    gw = (g == 1) ? m1_write      : m0_write;
    wd = (g == 1) ? m1_writedata  : m0_writedata;
    be = (g == 1) ? m1_byteenable : m0_byteenable;
    inr = int'(ga) < DEPTH;
    chk_eq("m0_waitrequest", 32'(m0_waitrequest), 32'(r0 && g != 0));
    chk_eq("m1_waitrequest", 32'(m1_waitrequest), 32'(r1 && g != 1));
    chk_eq("mem_clken", 32'(mem_clken), 32'(!reset_req));
    chk_eq("mem_address", 32'(mem_address), 32'(ga));
    chk_eq("mem_byteenable", 32'(mem_byteenable), 32'(be));
    chk_eq("mem_writedata", mem_writedata, wd);
    chk_eq("mem_chipselect", 32'(mem_chipselect), 32'(g >= 0 && inr));
    chk_eq("mem_write", 32'(mem_write), 32'(g >= 0 && gw && inr));
    chk_eq("m0_readdatavalid", 32'(m0_readdatavalid), 32'(pend_vld[0] && !reset));
    chk_eq("m1_readdatavalid", 32'(m1_readdatavalid), 32'(pend_vld[1] && !reset));
    chk_eq("m0_readdata", m0_readdata, (pend_vld[0] && !reset) ? pend_data[0] : 32'h0);
    chk_eq("m1_readdata", m1_readdata, (pend_vld[1] && !reset) ? pend_data[1] : 32'h0);
    chk_eq("m0_oor", 32'(m0_oor), 32'(pend_oor[0] && !reset));
    chk_eq("m1_oor", 32'(m1_oor), 32'(pend_oor[1] && !reset));
    @(posedge clk);
    pend_vld = '0;
    pend_oor = '0;
    pend_data[0] = '0;
    pend_data[1] = '0;
    if (reset) begin
      last_w = 1;
    end else if (g >= 0) begin
      if (gw) begin
        if (inr)
          for (int b = 0; b < 4; b++)
            if (be[b]) model_mem[ga][8*b +: 8] = wd[8*b +: 8];
      end else begin
        pend_vld[g] = 1'b1;
        if (inr) pend_data[g] = model_mem[ga];
      end
      pend_oor[g] = !inr;
      last_w = g;
    end
    gnt = g;
    #1;
  endtask

  task automatic set_m(input int n, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  // Steps until every posted request has been granted; a master drops its request once granted.
  task automatic run_until_done(input string tag);
    int budget = 20;
    while ((m0_read || m0_write || m1_read || m1_write) && budget > 0) begin
      step();
      if (gnt == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
      if (gnt == 1) begin m1_read = 1'b0; m1_write = 1'b0; end
      budget--;
    end
    chk_eq(tag, 32'(m0_read || m0_write || m1_read || m1_write), 32'h0);
  endtask

  initial begin
    int n1, waited;
    int bad;
    reset = 1'b1; reset_req = 1'b0; ram_clr = 1'b1;
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    last_w = 1; pend_vld = '0; pend_oor = '0; pend_data[0] = '0; pend_data[1] = '0; gnt = -1;
    step();
    ram_clr = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Write then read back on m0
    set_m(0, 0, 1, 13'h0010, 4'hF, 32'hA5A5_1234);
    run_until_done("t1_wr_done");
    set_m(0, 1, 0, 13'h0010, 4'hF, 32'h0);
    run_until_done("t1_rd_done");
    chk_eq("t1_rdata", m0_readdata, 32'hA5A5_1234);
    chk_eq("t1_vld", 32'(m0_readdatavalid), 32'h1);
    chk_eq("t1_m1vld", 32'(m1_readdatavalid), 32'h0);
    step();

    // Continuous contention
    set_m(0, 1, 0, 13'h0001, 4'hF, 32'h0);
    set_m(1, 1, 0, 13'h0002, 4'hF, 32'h0);
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (gnt == 1) n1++;
    end
    chk_eq("t2_m1_grants", 32'(n1), FIXED ? 32'd0 : 32'd4);
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
    step();

    // Partial byte-enable write
    set_m(1, 0, 1, 13'h1000, 4'hF, 32'h1122_3344);
    run_until_done("t3_wr0_done");
    set_m(1, 0, 1, 13'h1000, 4'b0010, 32'hFFFF_FFFF);
    run_until_done("t3_wr1_done");
    set_m(1, 1, 0, 13'h1000, 4'hF, 32'h0);
    run_until_done("t3_rd_done");
    chk_eq("t3_rdata", m1_readdata, 32'h1122_FF44);
    step();

    // Out-of-range read and write together
    set_m(0, 1, 0, 13'h1400, 4'hF, 32'h0);
    set_m(1, 0, 1, 13'h1FFF, 4'hF, 32'hDEAD_BEEF);
    run_until_done("t4_done");
    step();
    step();

    // reset_req stall
    set_m(0, 1, 0, 13'h0010, 4'hF, 32'h0);
    reset_req = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset_req = 1'b0;
    waited = 0;
    while ((m0_read || m0_write) && waited < 10) begin
      step();
      waited++;
      if (gnt == 0) m0_read = 1'b0;
    end
    chk_eq("t5_grant_latency", 32'(waited), 32'd1);
    step();

    // Reset with an m1 read in flight
    set_m(1, 1, 0, 13'h1000, 4'hF, 32'h0);
    step();
    set_m(1, 0, 0, '0, '0, '0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    set_m(0, 1, 0, 13'h0001, 4'hF, 32'h0);
    set_m(1, 1, 0, 13'h0002, 4'hF, 32'h0);
    step();
    chk_eq("t6_first_winner", 32'(gnt), 32'd0);
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
    step();

    // Random traffic; stalled masters hold their request
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        bit held;
        int op;
        logic [AW-1:0] a;
        held = (n == 0) ? ((m0_read || m0_write) && gnt != 0)
                        : ((m1_read || m1_write) && gnt != 1);
        if (!held) begin
          op = $urandom_range(0, 9);
          if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(DEPTH, 8191));
          else                           a = AW'($urandom_range(0, 63));
          set_m(n, op >= 4 && op < 7, op >= 7, a, 4'($urandom_range(0, 15)), $urandom);
        end
      end
      reset_req = ($urandom_range(0, 15) == 0);
      step();
    end
    reset_req = 1'b0;
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
    step();
    step();

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== model_mem[i]) bad++;
    chk_eq("ram_contents", 32'(bad), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
